// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with byte FIFO; optional even parity via UART_TX_PARITY_EN
module uart_tx_fifo #(
   parameter int CLK_HZ  = 12000000,
   parameter int BAUD    = 9600,
   parameter int FIFO_AW = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] wr_data,
   input  logic       wr_en,
   output logic       full,
   output logic       overflow,
   output logic       busy,
   output logic       txd
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [BW-1:0]    BAUD_LOAD  = BW'(DIV - 1);
   localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               empty;
   logic               push;
   logic               pop;

   logic [2:0]         state;
   logic [BW-1:0]      baud_cnt;
   logic               baud_tick;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
`ifdef UART_TX_PARITY_EN
   logic               par_bit;
`endif

   // full/empty are decoded from the registered count, so a write that
   // coincides with a pop while full is still refused
   assign full      = (count == COUNT_FULL);
   assign empty     = (count == '0);
   assign push      = wr_en && !full;
   assign baud_tick = (baud_cnt == '0);
   assign pop       = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_tick));
   assign busy      = (state != S_IDLE) || !empty;

   // FIFO storage; contents need no reset because count gates every read
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // sticky overflow: set by any write that arrives while full
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end
   end

   // frame sequencer: every txd level is held for exactly DIV cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         txd      <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  shift    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                  par_bit  <= ^mem[rd_ptr];
`endif
                  txd      <= 1'b0;
                  baud_cnt <= BAUD_LOAD;
                  state    <= S_START;
               end else begin
                  txd      <= 1'b1;
               end
            end
            S_START: begin
               if (baud_tick) begin
                  txd      <= shift[0];
                  baud_cnt <= BAUD_LOAD;
                  bit_idx  <= '0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     txd   <= par_bit;
                     state <= S_PARITY;
`else
                     txd   <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     // shift[0] is on the line; the next bit moves down
                     txd     <= shift[1];
                     shift   <= {1'b0, shift[7:1]};
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_tick) begin
                  txd      <= 1'b1;
                  baud_cnt <= BAUD_LOAD;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (baud_tick) begin
                  baud_cnt <= BAUD_LOAD;
                  if (!empty) begin
                     // chain straight into the next start bit, no idle gap
                     shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                     par_bit <= ^mem[rd_ptr];
`endif
                     txd     <= 1'b0;
                     state   <= S_START;
                  end else begin
                     txd     <= 1'b1;
                     state   <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: begin
               txd   <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter for the l80soc serial port. It drives the txd pin with 8N1 frames at a fixed baud rate derived from the system clock. A small FIFO lets the 8080 core queue bytes without polling per character. It is the transmit-side counterpart of the serial stimulus the SoC bench drives on rxd.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_HZ/BAUD (integer division, 1250 at defaults)
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (4 at default)

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
wr_data  in  8  byte to queue
wr_en  in  1  write strobe; one byte per cycle in which it is high
full  out  1  FIFO holds 2**FIFO_AW bytes
overflow  out  1  sticky flag: a write arrived while full
busy  out  1  FSM not IDLE, or FIFO not empty
txd  out  1  serial output, idle high, registered

Behaviour:
- Reset (asynchronous, takes effect immediately): txd=1, full=0, overflow=0, busy=0, FIFO emptied, FSM=IDLE, baud counter=0, bit index=0. Reset asserted mid-frame truncates the frame; txd goes high at once.
- FIFO:
  - wr_en && !full writes wr_data at the write pointer; pointers wrap modulo depth.
  - full/empty come from a count register of FIFO_AW+1 bits.
  - wr_en while full: the byte is dropped and overflow is set to 1. Only reset clears overflow.
  - full is the registered state. A write in the same cycle as a pop while full is still dropped.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head into the shift register, set txd=0, load the baud counter and go to START. Otherwise txd=1.
  - START: txd=0 for DIV cycles, then txd=shift[0] and go to DATA.
  - DATA: each bit is held DIV cycles, LSB first. After bit 7, txd=1 and go to STOP.
  - STOP: txd=1 for DIV cycles. At the end, if the FIFO is not empty, pop and go straight to START (txd=0 on that same edge, no idle gap). Otherwise go to IDLE.
- Baud counter counts DIV-1 down to 0. A bit boundary occurs on the edge where the counter is 0; the counter reloads there.
- Latency: a write on edge k into an empty FIFO with the FSM in IDLE puts txd=0 after edge k+1.
- Every txd level lasts exactly DIV clock cycles. One frame lasts 10*DIV cycles. Back-to-back frames have period exactly 10*DIV.
- busy falls on the edge that ends the last stop bit with the FIFO empty.
- DIV < 2 is unsupported. No runtime check is made.

Optional Feature:
UART_TX_PARITY_EN
- Defined: an even-parity bit (XOR of the 8 data bits) is sent after bit 7 for DIV cycles, in extra state PARITY, before STOP. Frame = 11*DIV cycles.
- Undefined: no PARITY state or logic, 8N1 only, frame = 10*DIV cycles.

Test Plan:
- Idle after reset, then 5000 cycles with no writes -> txd=1, busy=0, full=0, overflow=0 throughout.
- Write 0x36 at edge k, DIV=1250 -> txd low from k+1. Sampling at bit centres gives 0 | 0,1,1,0,1,1,0,0 | 1. busy drops at k+1+12500. With UART_TX_PARITY_EN, parity bit 0 is inserted and busy drops at k+1+13750.
- Write 0x55, 0xAA, 0x01 on consecutive cycles -> three contiguous frames. The stop bit of each is followed directly by the next start bit. Total 37500 cycles of busy, decoded bytes in order.
- Five writes on consecutive cycles with the FSM idle -> the first is popped at once, so four more fill the FIFO. full=1 after the fifth write; a sixth write while full sets overflow=1 and that byte is never transmitted.
- Assert reset at cycle 3000 of a frame -> txd=1, busy=0, full=0 immediately and asynchronously. A new write after release produces a complete, correctly timed frame.
- Write while FIFO full in the same cycle the STOP-end pop occurs -> byte dropped, overflow=1, count decremented by 1.
